i2c_master_burst: RTL and testbench

- Parametrised successor to the single-byte OLED I2C master.
- Runs complete I2C transactions: START, 7-bit address + R/W, N data bytes, STOP.
- Write bytes arrive on a valid/ready stream; read bytes leave on a valid pulse.
- Slave ACK is checked on every byte, with NACK abort; SCL rate is set by parameter.
- Sits between display/sensor command sequencers (SSD1306 init/framebuffer streamer) and the open-drain bus pins.

---
 rtl/i2c_pkg.sv | 33 +++
 rtl/i2c_tick_gen.sv | 30 +++
 rtl/i2c_master_burst.sv | 247 ++++++++++++++++++++++++
 tb/tb_i2c_master_burst.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the burst I2C master: FSM encoding, bit phases,
// ACK levels and the clock-stretch timeout.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_ADDR      = 4'd2,
    ST_ADDR_ACK  = 4'd3,
    ST_WR_BYTE   = 4'd4,
    ST_WR_ACK    = 4'd5,
    ST_RD_BYTE   = 4'd6,
    ST_RD_ACK    = 4'd7,
    ST_STOP      = 4'd8,
    ST_WAIT_DATA = 4'd9
  } state_t;

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int I2C_STRETCH_TIMEOUT = 65535;

  // States that run the 4-phase SCL bit clock
  function automatic logic in_bit_state(input state_t s);
    return s inside {ST_ADDR, ST_ADDR_ACK, ST_WR_BYTE, ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK};
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick generator: one-cycle tick every CLK_DIV clocks,
// held at zero by clear and paused (count frozen) by freeze.
module i2c_tick_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic freeze,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!freeze) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = !clear && !freeze && (cnt == LAST);

endmodule

// File: rtl/i2c_master_burst.sv
// Burst I2C master: START, address+R/W, len data bytes with per-byte ACK check, STOP.
// Optional slave clock stretching is enabled with the I2C_CLK_STRETCH_EN macro.
module i2c_master_burst
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       addr,
  input  logic             rw,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  inout  wire              sda,
  inout  wire              scl,
  output logic [3:0]       state,
  output logic [LEN_W-1:0] byte_cnt
);

  state_t           st, st_nx;
  logic [1:0]       ph, ph_nx;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             rw_r;
  logic [LEN_W-1:0] len_r;
  logic             ack_r;
  logic             sda_in;
  logic             sda_low, scl_low;

  logic tick, tick_clear, freeze, stretch_to;
  logic accept, bit_end, shift_out, sample_ack, inc_cnt;
  logic sample_rd, fire_rd, fire_done, set_nack, ld_wr;

  assign sda_in = sda;

  // The divider idles whenever SCL is parked low or the bus is free, so
  // every byte starts on a fresh quarter period.
  assign tick_clear = (st == ST_IDLE) || (st == ST_WAIT_DATA);

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (tick_clear),
    .freeze (freeze),
    .tick   (tick)
  );

`ifdef I2C_CLK_STRETCH_EN
  logic        scl_in;
  logic        stretching;
  logic [15:0] stretch_cnt;

  assign scl_in     = scl;
  assign stretching = (in_bit_state(st) || st == ST_STOP) && (ph == PH_1) && (scl_in == 1'b0);
  assign freeze     = stretching;
  assign stretch_to = stretching && (stretch_cnt == 16'(I2C_STRETCH_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stretch_cnt <= '0;
    end else begin
      stretch_cnt <= stretching ? stretch_cnt + 16'd1 : '0;
    end
  end
`else
  assign freeze     = 1'b0;
  assign stretch_to = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= ST_IDLE;
      ph <= PH_0;
    end else begin
      st <= st_nx;
      ph <= ph_nx;
    end
  end

  always_comb begin
    st_nx      = st;
    ph_nx      = tick ? ph + 2'd1 : ph;
    accept     = 1'b0;
    bit_end    = 1'b0;
    shift_out  = 1'b0;
    sample_ack = 1'b0;
    inc_cnt    = 1'b0;
    sample_rd  = 1'b0;
    fire_rd    = 1'b0;
    fire_done  = 1'b0;
    set_nack   = 1'b0;
    ld_wr      = 1'b0;
    case (st)
      ST_IDLE: begin
        ph_nx = PH_0;
        // done high means STOP just finished; the bus gets one free cycle
        if (start && !done) begin
          accept = 1'b1;
          st_nx  = ST_START;
        end
      end
      ST_START: begin
        if (tick && ph == PH_1) begin
          st_nx = ST_ADDR;
          ph_nx = PH_0;
        end
      end
      ST_ADDR, ST_WR_BYTE: begin
        if (tick && ph == PH_3) begin
          bit_end   = 1'b1;
          shift_out = 1'b1;
          if (bit_cnt == 3'd7) st_nx = (st == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
        end
      end
      ST_ADDR_ACK: begin
        if (tick && ph == PH_2) sample_ack = 1'b1;
        if (tick && ph == PH_3) begin
          if (ack_r == NACK || len_r == '0) st_nx = ST_STOP;
          else if (rw_r)                    st_nx = ST_RD_BYTE;
          else                              st_nx = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        ph_nx = PH_0;
        if (wr_valid) begin
          ld_wr = 1'b1;
          st_nx = ST_WR_BYTE;
        end
      end
      ST_WR_ACK: begin
        if (tick && ph == PH_2) begin
          sample_ack = 1'b1;
          inc_cnt    = 1'b1;
        end
        if (tick && ph == PH_3)
          st_nx = (ack_r == NACK || byte_cnt == len_r) ? ST_STOP : ST_WAIT_DATA;
      end
      ST_RD_BYTE: begin
        if (tick && ph == PH_2) begin
          sample_rd = 1'b1;
          if (bit_cnt == 3'd7) begin
            fire_rd = 1'b1;
            inc_cnt = 1'b1;
          end
        end
        if (tick && ph == PH_3) begin
          bit_end = 1'b1;
          if (bit_cnt == 3'd7) st_nx = ST_RD_ACK;
        end
      end
      ST_RD_ACK: begin
        if (tick && ph == PH_3) st_nx = (byte_cnt < len_r) ? ST_RD_BYTE : ST_STOP;
      end
      ST_STOP: begin
        if (tick && ph == PH_2) begin
          st_nx     = ST_IDLE;
          ph_nx     = PH_0;
          fire_done = 1'b1;
        end
      end
      default: begin
        st_nx = ST_IDLE;
        ph_nx = PH_0;
      end
    endcase
    if (sample_ack && sda_in == NACK) set_nack = 1'b1;
    if (stretch_to) begin
      st_nx    = ST_STOP;
      ph_nx    = PH_0;
      set_nack = 1'b1;
    end
  end

  // Status and counters (reset by rst)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      nack     <= 1'b0;
      byte_cnt <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_valid <= fire_rd;
      done     <= fire_done;
      if (accept) begin
        nack     <= 1'b0;
        byte_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (set_nack) nack     <= 1'b1;
        if (inc_cnt)  byte_cnt <= byte_cnt + LEN_W'(1);
        if (bit_end)  bit_cnt  <= bit_cnt + 3'd1;
      end
      if (fire_rd) rd_data <= {shreg[6:0], sda_in};
    end
  end

  // Byte datapath, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= {addr, rw};
      rw_r  <= rw;
      len_r <= len;
    end else if (ld_wr) begin
      shreg <= wr_data;
    end else if (shift_out) begin
      shreg <= {shreg[6:0], 1'b0};
    end else if (sample_rd) begin
      shreg <= {shreg[6:0], sda_in};
    end
    if (sample_ack) ack_r <= sda_in;
  end

  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    if (in_bit_state(st)) scl_low = (ph == PH_0) || (ph == PH_3);
    case (st)
      ST_START:             sda_low = (ph != PH_0);
      ST_ADDR, ST_WR_BYTE:  sda_low = ~shreg[7];
      ST_RD_ACK:            sda_low = ((byte_cnt < len_r) ? ACK : NACK) == ACK;
      ST_WAIT_DATA:         scl_low = 1'b1;
      ST_STOP: begin
        scl_low = (ph == PH_0);
        sda_low = (ph != PH_2);
      end
      default: ;
    endcase
  end

  assign sda      = sda_low ? 1'b0 : 1'bz;
  assign scl      = scl_low ? 1'b0 : 1'bz;
  assign wr_ready = ld_wr;
  assign busy     = (st != ST_IDLE);
  assign state    = st;

endmodule

// File: tb/tb_i2c_master_burst.sv
// Directed bench for i2c_master_burst with a behavioural slave at 0x3C on a
// pulled-up bus; the stretch step is built only with I2C_CLK_STRETCH_EN.
module tb_i2c_master_burst;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr = '0;
  logic       rw = 1'b0;
  logic [7:0] len = '0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready, rd_valid, busy, done, nack;
  logic [7:0] rd_data, byte_cnt;
  logic [3:0] state;
  wire        sda, scl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pullup (sda);
  pullup (scl);

  i2c_master_burst #(.CLK_DIV(4), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .len(len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .nack(nack),
    .sda(sda), .scl(scl), .state(state), .byte_cnt(byte_cnt)
  );

  // Behavioural slave, sampled on clk
  localparam int S_IDLE = 0, S_ADDR = 1, S_AACK = 2, S_WRX = 3, S_WACK = 4, S_RDX = 5, S_RACK = 6;
  logic       sl_drive = 1'b0;
  logic       tb_scl_low = 1'b0;
  logic       psda = 1'b1, pscl = 1'b1;
  int         sst = S_IDLE;
  int         sbits = 0;
  logic [7:0] ssh = '0, stx = '0;
  logic       srnw = 1'b0, mlast = 1'b1;
  int         s_txi = 0;
  logic [7:0] blog [0:63];
  int         nb = 0;
  logic       mlog [0:15];
  int         nm = 0;
  int         nstop = 0;

  assign sda = sl_drive ? 1'b0 : 1'bz;
  assign scl = tb_scl_low ? 1'b0 : 1'bz;

  function automatic logic [7:0] tx_byte(input int i);
    return (i == 0) ? 8'hA5 : 8'h5A;
  endfunction

  function automatic logic tx_low(input int i);
    logic [7:0] b;
    b = tx_byte(i);
    return ~b[7];
  endfunction

  always @(posedge clk) begin
    psda <= sda;
    pscl <= scl;
    if (pscl && scl && psda && !sda) begin
      sst <= S_ADDR; sbits <= 0; sl_drive <= 1'b0; s_txi <= 0;
    end else if (pscl && scl && !psda && sda) begin
      sst <= S_IDLE; sl_drive <= 1'b0; nstop <= nstop + 1;
    end else if (!pscl && scl) begin
      if (sst == S_ADDR || sst == S_WRX) begin
        ssh <= {ssh[6:0], sda}; sbits <= sbits + 1;
      end else if (sst == S_RDX) begin
        sbits <= sbits + 1;
      end else if (sst == S_RACK) begin
        mlog[nm] <= sda; nm <= nm + 1; mlast <= sda;
      end
    end else if (pscl && !scl) begin
      case (sst)
        S_ADDR: if (sbits == 8) begin
          blog[nb] <= ssh; nb <= nb + 1;
          if (ssh[7:1] == 7'h3C) begin
            sl_drive <= 1'b1; srnw <= ssh[0]; sst <= S_AACK;
          end else begin
            sst <= S_IDLE;
          end
        end
        S_AACK: begin
          sbits <= 0;
          if (srnw) begin
            stx <= tx_byte(s_txi); sl_drive <= tx_low(s_txi); sst <= S_RDX;
          end else begin
            sl_drive <= 1'b0; sst <= S_WRX;
          end
        end
        S_WRX: if (sbits == 8) begin
          blog[nb] <= ssh; nb <= nb + 1; sl_drive <= 1'b1; sst <= S_WACK;
        end
        S_WACK: begin
          sl_drive <= 1'b0; sbits <= 0; sst <= S_WRX;
        end
        S_RDX: if (sbits == 8) begin
          sl_drive <= 1'b0; sst <= S_RACK; s_txi <= s_txi + 1;
        end else begin
          stx <= {stx[6:0], 1'b0}; sl_drive <= ~stx[6];
        end
        S_RACK: if (mlast == 1'b0) begin
          stx <= tx_byte(s_txi); sl_drive <= tx_low(s_txi); sbits <= 0; sst <= S_RDX;
        end else begin
          sl_drive <= 1'b0; sst <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Handshake and pulse monitor
  int         wr_seen = 0, rd_seen = 0;
  logic [7:0] rd_log [0:15];
  always @(posedge clk) begin
    if (wr_ready) wr_seen <= wr_seen + 1;
    if (rd_valid) begin
      rd_log[rd_seen] <= rd_data;
      rd_seen <= rd_seen + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [6:0] a, input logic r, input logic [7:0] l);
    @(negedge clk);
    addr = a; rw = r; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    int n = 0;
    while (state !== s && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, state, s);
  endtask

  task automatic feed(input logic [7:0] b, input string tag);
    wait_state(4'd9, tag);
    wr_data = b; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1'b1);
  endtask

  int nb0, wr0, rd0, st0, nm0, v_scl, v_st, falls;
  logic pv;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", state, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_nack", nack, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_byte_cnt", byte_cnt, 8'd0);
    chk("rst_sda", sda, 1'b1);
    chk("rst_scl", scl, 1'b1);
    rst = 1'b0;

    // Write burst 0x00, 0xAF to 0x3C
    nb0 = nb; wr0 = wr_seen; st0 = nstop;
    do_start(7'h3C, 1'b0, 8'd2);
    chk("wr_busy", busy, 1'b1);
    chk("wr_state_start", state, 4'd1);
    feed(8'h00, "wr_wait1");
    feed(8'hAF, "wr_wait2");
    wait_done("wr_done");
    chk("wr_busy_low", busy, 1'b0);
    @(negedge clk);
    chk("wr_nbytes", nb - nb0, 3);
    chk("wr_byte0", blog[nb0], 8'h78);
    chk("wr_byte1", blog[nb0 + 1], 8'h00);
    chk("wr_byte2", blog[nb0 + 2], 8'hAF);
    chk("wr_ready_pulses", wr_seen - wr0, 2);
    chk("wr_byte_cnt", byte_cnt, 8'd2);
    chk("wr_nack", nack, 1'b0);
    chk("wr_stop", nstop - st0, 1);

    // Address NACK, then a start in the done cycle
    nb0 = nb; wr0 = wr_seen; st0 = nstop;
    do_start(7'h3D, 1'b0, 8'd1);
    wait_done("an_done");
    chk("an_nack", nack, 1'b1);
    addr = 7'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_cycle_start_state", state, 4'd0);
    chk("done_cycle_start_busy", busy, 1'b0);
    chk("an_addr_byte", blog[nb0], 8'h7A);
    chk("an_no_wr_ready", wr_seen - wr0, 0);
    chk("an_byte_cnt", byte_cnt, 8'd0);
    chk("an_stop", nstop - st0, 1);

    // Data stall for 100 cycles in WAIT_DATA
    nb0 = nb;
    do_start(7'h3C, 1'b0, 8'd1);
    chk("nack_cleared", nack, 1'b0);
    wait_state(4'd9, "stall_enter");
    v_scl = 0; v_st = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (scl !== 1'b0) v_scl++;
      if (state !== 4'd9) v_st++;
    end
    chk("stall_scl_low", v_scl, 0);
    chk("stall_state", v_st, 0);
    feed(8'h3A, "stall_resume");
    wait_done("stall_done");
    @(negedge clk);
    chk("stall_byte", blog[nb0 + 1], 8'h3A);
    chk("stall_byte_cnt", byte_cnt, 8'd1);
    chk("stall_nack", nack, 1'b0);

    // Read burst: slave returns 0xA5, 0x5A
    rd0 = rd_seen; nm0 = nm; st0 = nstop;
    do_start(7'h3C, 1'b1, 8'd2);
    wait_done("rd_done");
    @(negedge clk);
    chk("rd_pulses", rd_seen - rd0, 2);
    chk("rd_data0", rd_log[rd0], 8'hA5);
    chk("rd_data1", rd_log[rd0 + 1], 8'h5A);
    chk("rd_data_held", rd_data, 8'h5A);
    chk("rd_master_ack1", mlog[nm0], 1'b0);
    chk("rd_master_nack2", mlog[nm0 + 1], 1'b1);
    chk("rd_byte_cnt", byte_cnt, 8'd2);
    chk("rd_nack", nack, 1'b0);
    chk("rd_stop", nstop - st0, 1);

    // Reset during WR_BYTE bit 3, then a clean transfer
    do_start(7'h3C, 1'b0, 8'd1);
    feed(8'h00, "rw_feed");
    wait_state(4'd4, "rw_wr_byte");
    falls = 0; pv = scl;
    for (int i = 0; i < 200 && falls < 3; i++) begin
      @(negedge clk);
      if (pv === 1'b1 && scl === 1'b0) falls++;
      pv = scl;
    end
    repeat (6) @(negedge clk);
    chk("rw_pre_state", state, 4'd4);
    chk("rw_pre_sda", sda, 1'b0);
    chk("rw_pre_scl", scl, 1'b0);
    rst = 1'b1;
    #1;
    chk("rw_sda_rel", sda, 1'b1);
    chk("rw_scl_rel", scl, 1'b1);
    chk("rw_busy", busy, 1'b0);
    chk("rw_state", state, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    nb0 = nb;
    do_start(7'h3C, 1'b0, 8'd1);
    feed(8'h5C, "rw_again_feed");
    wait_done("rw_again_done");
    @(negedge clk);
    chk("rw_again_addr", blog[nb0], 8'h78);
    chk("rw_again_byte", blog[nb0 + 1], 8'h5C);
    chk("rw_again_nack", nack, 1'b0);

`ifdef I2C_CLK_STRETCH_EN
    // Slave stretches SCL for 50 cycles on address bit 0
    nb0 = nb;
    do_start(7'h3C, 1'b0, 8'd1);
    wait_state(4'd2, "st_addr");
    tb_scl_low = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 40) begin
        chk("st_held_scl", scl, 1'b0);
        chk("st_held_state", state, 4'd2);
      end
    end
    tb_scl_low = 1'b0;
    @(negedge clk);
    chk("st_release_high", scl, 1'b1);
    feed(8'h11, "st_feed");
    wait_done("st_done");
    @(negedge clk);
    chk("st_addr_byte", blog[nb0], 8'h78);
    chk("st_data_byte", blog[nb0 + 1], 8'h11);
    chk("st_nack", nack, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
